// File: rtl/sonar_scan_controller.sv
// Sweep sequencer for the sonar: steps the servo ping-pong over NUM_POS positions,
// settles, triggers one measurement and walks the UART through a NUM_CHARS frame.
module sonar_scan_controller #(
    parameter int SETTLE_CYCLES  = 25_000_000,
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int NUM_POS        = 8,
    parameter int NUM_CHARS      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       medida_pronto,
    input  logic       tx_pronto,
    output logic       medir,
    output logic       transmitir,
    output logic [2:0] sel_char,
    output logic [2:0] posicao,
    output logic       fim_posicao,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       POS_LAST     = 3'(NUM_POS - 1);
    localparam logic [2:0]       CHAR_LAST    = 3'(NUM_CHARS - 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        ESPERA         = 4'd1,
        MEDE           = 4'd2,
        AGUARDA_MEDIDA = 4'd3,
        TRANSMITE      = 4'd4,
        AGUARDA_TX     = 4'd5,
        PROXIMO_CHAR   = 4'd6,
        ATUALIZA_POS   = 4'd7
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic [2:0]       sel_char_r, sel_char_s;
    logic [2:0]       posicao_r, posicao_s;
    logic             dir_up_r, dir_up_s;
    logic             timeout_s;
    logic             medir_r, transmitir_r, fim_posicao_r, timeout_r;

    // Next-state, counter and datapath-register decisions.
    // The counter is zero in the first cycle of ESPERA and of MEDE, so the
    // measurement window (MEDE + AGUARDA_MEDIDA) spans TIMEOUT_CYCLES cycles.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        sel_char_s = sel_char_r;
        posicao_s  = posicao_r;
        dir_up_s   = dir_up_r;
        timeout_s  = 1'b0;
        case (state_r)
            INICIAL: begin
                if (ligar) begin
                    state_s = ESPERA;
                    count_s = CNT_ZERO;
                end else begin
                    state_s = INICIAL;
                end
            end
            ESPERA: begin
                if (count_r >= SETTLE_LAST) begin
                    state_s = MEDE;
                    count_s = CNT_ZERO;
                end else begin
                    count_s = count_r + CNT_ONE;
                end
            end
            MEDE: begin
                state_s = AGUARDA_MEDIDA;
                count_s = count_r + CNT_ONE;
            end
            AGUARDA_MEDIDA: begin
                if (medida_pronto) begin
                    state_s    = TRANSMITE;
                    sel_char_s = 3'd0;
                end else if (count_r >= TIMEOUT_LAST) begin
                    state_s    = TRANSMITE;
                    sel_char_s = 3'd0;
                    timeout_s  = 1'b1;
                end else begin
                    count_s = count_r + CNT_ONE;
                end
            end
            TRANSMITE: begin
                state_s = AGUARDA_TX;
            end
            AGUARDA_TX: begin
                if (!tx_pronto) begin
                    state_s = AGUARDA_TX;
                end else if (sel_char_r == CHAR_LAST) begin
                    state_s = ATUALIZA_POS;
                end else begin
                    state_s = PROXIMO_CHAR;
                end
            end
            PROXIMO_CHAR: begin
                state_s    = TRANSMITE;
                sel_char_s = sel_char_r + 3'd1;
            end
            ATUALIZA_POS: begin
                if (dir_up_r) begin
                    if (posicao_r == POS_LAST) begin
                        dir_up_s  = 1'b0;
                        posicao_s = POS_LAST - 3'd1;
                    end else begin
                        posicao_s = posicao_r + 3'd1;
                    end
                end else begin
                    if (posicao_r == 3'd0) begin
                        dir_up_s  = 1'b1;
                        posicao_s = 3'd1;
                    end else begin
                        posicao_s = posicao_r - 3'd1;
                    end
                end
                if (ligar) begin
                    state_s = ESPERA;
                    count_s = CNT_ZERO;
                end else begin
                    state_s = INICIAL;
                end
            end
            default: begin
                state_s = INICIAL;
                count_s = CNT_ZERO;
            end
        endcase
    end

    // State, datapath and registered pulse outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= INICIAL;
            count_r       <= CNT_ZERO;
            sel_char_r    <= 3'd0;
            posicao_r     <= 3'd0;
            dir_up_r      <= 1'b1;
            medir_r       <= 1'b0;
            transmitir_r  <= 1'b0;
            fim_posicao_r <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            count_r       <= count_s;
            sel_char_r    <= sel_char_s;
            posicao_r     <= posicao_s;
            dir_up_r      <= dir_up_s;
            medir_r       <= (state_s == MEDE);
            transmitir_r  <= (state_s == TRANSMITE);
            fim_posicao_r <= (state_s == ATUALIZA_POS);
            timeout_r     <= timeout_s;
        end
    end

    assign medir       = medir_r;
    assign transmitir  = transmitir_r;
    assign fim_posicao = fim_posicao_r;
    assign timeout     = timeout_r;
    assign sel_char    = sel_char_r;
    assign posicao     = posicao_r;
    assign db_estado   = state_r;

endmodule

// File: tb/tb_sonar_scan_controller.sv
// Self-checking bench for sonar_scan_controller: a responder plays the sensor and
// UART, expected characters/positions go into queues and are matched against DUT output.
module tb_sonar_scan_controller;

    localparam int SETTLE = 10;
    localparam int TMO    = 100;
    localparam int NPOS   = 4;
    localparam int NCH    = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ligar = 1'b0;
    logic       medida_pronto = 1'b0;
    logic       tx_pronto = 1'b0;
    logic       medir, transmitir, fim_posicao, timeout;
    logic [2:0] sel_char, posicao;
    logic [3:0] db_estado;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int esp_at, medir_at, first_tx_at, last_tx_at, tmo_at;
    int n_medir, n_tx, n_fim, n_timeout;
    int obs_sel_q[$], exp_sel_q[$], obs_pos_q[$], exp_pos_q[$];
    int m_pos;
    bit m_up;

    always #5 clock = ~clock;

    sonar_scan_controller #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO),
        .NUM_POS       (NPOS),
        .NUM_CHARS     (NCH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ligar        (ligar),
        .medida_pronto(medida_pronto),
        .tx_pronto    (tx_pronto),
        .medir        (medir),
        .transmitir   (transmitir),
        .sel_char     (sel_char),
        .posicao      (posicao),
        .fim_posicao  (fim_posicao),
        .timeout      (timeout),
        .db_estado    (db_estado)
    );

    task automatic tick;
        @(negedge clock);
        medida_pronto = 1'b0;
        tx_pronto     = 1'b0;
        cyc++;
    endtask

    task automatic model_step;
        if (m_up) begin
            if (m_pos == NPOS - 1) begin m_up = 1'b0; m_pos = NPOS - 2; end
            else m_pos++;
        end else begin
            if (m_pos == 0) begin m_up = 1'b1; m_pos = 1; end
            else m_pos--;
        end
    endtask

    task automatic clear_stats;
        n_medir = 0; n_tx = 0; n_fim = 0; n_timeout = 0;
        obs_sel_q.delete(); exp_sel_q.delete();
        obs_pos_q.delete(); exp_pos_q.delete();
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b0; ligar = 1'b0; medida_pronto = 1'b0; tx_pronto = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        m_pos = 0; m_up = 1'b1;
        clear_stats();
    endtask

    task automatic push_frame;
        for (int i = 0; i < NCH; i++) exp_sel_q.push_back(i);
    endtask

    // Environment for one position: answers medir after meas_delay cycles (never if <0),
    // answers each transmitir after 5 cycles, optionally drops ligar at char drop_sel.
    task automatic serve(input int meas_delay, input int drop_sel, output bit ok);
        ok = 1'b0;
        esp_at = -1; medir_at = -1; first_tx_at = -1; last_tx_at = -1; tmo_at = -1;
        for (int b = 0; b < 400; b++) begin
            tick();
            if (db_estado == 4'd1 && esp_at < 0) esp_at = cyc;
            if (medir) begin medir_at = cyc; n_medir++; obs_pos_q.push_back(int'(posicao)); end
            if (timeout) begin tmo_at = cyc; n_timeout++; end
            if (transmitir) begin
                if (first_tx_at < 0) first_tx_at = cyc;
                last_tx_at = cyc; n_tx++; obs_sel_q.push_back(int'(sel_char));
            end
            if (meas_delay >= 0 && medir_at >= 0 && cyc == medir_at + meas_delay) medida_pronto = 1'b1;
            if (last_tx_at >= 0 && cyc == last_tx_at + 5) begin
                tx_pronto = 1'b1;
                if (drop_sel >= 0 && int'(sel_char) == drop_sel) ligar = 1'b0;
            end
            if (fim_posicao) begin n_fim++; ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        int nm;
        repeat (2) @(negedge clock);
        checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", db_estado); end
        checks++; if ({medir, transmitir, fim_posicao, timeout} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {medir, transmitir, fim_posicao, timeout}); end
        checks++; if (sel_char !== 3'd0 || posicao !== 3'd0) begin errors++; $display("FAIL reset_regs: sel_char=%0d posicao=%0d expected 0 0", sel_char, posicao); end
        reset = 1'b1; ligar = 1'b0;
        nm = 0;
        repeat (6) begin tick(); if (medir) nm++; end
        checks++; if (db_estado !== 4'd0 || nm != 0) begin errors++; $display("FAIL idle_hold: state=%0d medir=%0d expected 0 0", db_estado, nm); end
    endtask

    task automatic test_single_position;
        bit ok; int o, e;
        do_reset();
        ligar = 1'b1;
        push_frame(); exp_pos_q.push_back(m_pos);
        serve(20, -1, ok);
        model_step();
        checks++; if (!ok) begin errors++; $display("FAIL single_done: got 0 expected 1 (cycle budget)"); end
        checks++; if (medir_at - esp_at != SETTLE) begin errors++; $display("FAIL settle_len: got %0d expected %0d", medir_at - esp_at, SETTLE); end
        checks++; if (n_tx != NCH) begin errors++; $display("FAIL single_tx_count: got %0d expected %0d", n_tx, NCH); end
        while (obs_sel_q.size() > 0) begin
            o = obs_sel_q.pop_front();
            e = -1; if (exp_sel_q.size() > 0) e = exp_sel_q.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL single_sel_char: got %0d expected %0d", o, e); end
        end
        o = -1; if (obs_pos_q.size() > 0) o = obs_pos_q.pop_front();
        e = exp_pos_q.pop_front();
        checks++; if (o != e) begin errors++; $display("FAIL single_pos: got %0d expected %0d", o, e); end
        checks++; if (n_fim != 1 || n_timeout != 0) begin errors++; $display("FAIL single_pulses: fim=%0d timeout=%0d expected 1 0", n_fim, n_timeout); end
        tick();
        checks++; if (posicao !== 3'(m_pos)) begin errors++; $display("FAIL single_advance: got %0d expected %0d", posicao, m_pos); end
    endtask

    task automatic test_sweep;
        bit ok; int o, e;
        do_reset();
        ligar = 1'b1;
        for (int p = 0; p < 7; p++) begin
            exp_pos_q.push_back(m_pos); push_frame();
            serve(20, -1, ok);
            model_step();
            checks++; if (!ok) begin errors++; $display("FAIL sweep_done: position %0d got 0 expected 1", p); break; end
        end
        while (obs_pos_q.size() > 0) begin
            o = obs_pos_q.pop_front();
            e = -1; if (exp_pos_q.size() > 0) e = exp_pos_q.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL sweep_pos: got %0d expected %0d", o, e); end
        end
        while (obs_sel_q.size() > 0) begin
            o = obs_sel_q.pop_front();
            e = -1; if (exp_sel_q.size() > 0) e = exp_sel_q.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL sweep_sel_char: got %0d expected %0d", o, e); end
        end
        checks++; if (n_fim != 7 || n_medir != 7 || n_tx != 21) begin errors++; $display("FAIL sweep_counts: fim=%0d medir=%0d tx=%0d expected 7 7 21", n_fim, n_medir, n_tx); end
        tick();
        checks++; if (posicao !== 3'(m_pos)) begin errors++; $display("FAIL sweep_final_pos: got %0d expected %0d", posicao, m_pos); end
    endtask

    task automatic test_timeout;
        bit ok;
        do_reset();
        ligar = 1'b1;
        serve(-1, -1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_done: got 0 expected 1"); end
        checks++; if (n_timeout != 1 || tmo_at - medir_at != TMO) begin errors++; $display("FAIL timeout_delay: count=%0d delay=%0d expected 1 %0d", n_timeout, tmo_at - medir_at, TMO); end
        checks++; if (n_tx != NCH || n_fim != 1) begin errors++; $display("FAIL timeout_frame: tx=%0d fim=%0d expected %0d 1", n_tx, n_fim, NCH); end
    endtask

    task automatic test_timeout_race;
        bit ok;
        do_reset();
        ligar = 1'b1;
        serve(TMO - 1, -1, ok);
        checks++; if (n_timeout != 0) begin errors++; $display("FAIL race_timeout: got %0d expected 0", n_timeout); end
        checks++; if (first_tx_at - medir_at != TMO) begin errors++; $display("FAIL race_tx_start: got %0d expected %0d", first_tx_at - medir_at, TMO); end
        checks++; if (!ok || n_tx != NCH) begin errors++; $display("FAIL race_frame: done=%0d tx=%0d expected 1 %0d", ok, n_tx, NCH); end
    endtask

    task automatic test_ligar_drop;
        bit ok; int o, e, nm;
        do_reset();
        ligar = 1'b1;
        push_frame();
        serve(20, 1, ok);
        model_step();
        checks++; if (!ok || n_fim != 1 || n_tx != NCH) begin errors++; $display("FAIL drop_frame: done=%0d fim=%0d tx=%0d expected 1 1 %0d", ok, n_fim, n_tx, NCH); end
        while (obs_sel_q.size() > 0) begin
            o = obs_sel_q.pop_front();
            e = -1; if (exp_sel_q.size() > 0) e = exp_sel_q.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL drop_sel_char: got %0d expected %0d", o, e); end
        end
        tick();
        checks++; if (posicao !== 3'(m_pos) || db_estado !== 4'd0) begin errors++; $display("FAIL drop_park: pos=%0d state=%0d expected %0d 0", posicao, db_estado, m_pos); end
        nm = 0;
        repeat (30) begin tick(); if (medir) nm++; end
        checks++; if (nm != 0 || db_estado !== 4'd0) begin errors++; $display("FAIL drop_idle: medir=%0d state=%0d expected 0 0", nm, db_estado); end
        ligar = 1'b1;
        clear_stats();
        exp_pos_q.push_back(m_pos);
        serve(20, -1, ok);
        model_step();
        checks++; if (medir_at - esp_at != SETTLE) begin errors++; $display("FAIL resume_settle: got %0d expected %0d", medir_at - esp_at, SETTLE); end
        o = -1; if (obs_pos_q.size() > 0) o = obs_pos_q.pop_front();
        e = exp_pos_q.pop_front();
        checks++; if (o != e) begin errors++; $display("FAIL resume_pos: got %0d expected %0d", o, e); end
    endtask

    task automatic test_async_reset;
        bit ok; int o, e;
        do_reset();
        ligar = 1'b1;
        for (int p = 0; p < 4; p++) begin serve(20, -1, ok); model_step(); end
        tick();
        checks++; if (posicao !== 3'(m_pos) || m_up || db_estado !== 4'd1) begin errors++; $display("FAIL areset_setup: pos=%0d state=%0d expected %0d 1", posicao, db_estado, m_pos); end
        tick();
        tx_pronto = 1'b1;
        tick();
        checks++; if (transmitir !== 1'b0 || db_estado !== 4'd1) begin errors++; $display("FAIL spurious_tx: transmitir=%0d state=%0d expected 0 1", transmitir, db_estado); end
        #2 reset = 1'b0;
        #1;
        checks++; if (db_estado !== 4'd0 || posicao !== 3'd0 || sel_char !== 3'd0) begin errors++; $display("FAIL areset_regs: state=%0d pos=%0d sel=%0d expected 0 0 0", db_estado, posicao, sel_char); end
        checks++; if ({medir, transmitir, fim_posicao, timeout} !== 4'b0000) begin errors++; $display("FAIL areset_pulses: got %b expected 0000", {medir, transmitir, fim_posicao, timeout}); end
        @(negedge clock);
        reset = 1'b1; ligar = 1'b1;
        m_pos = 0; m_up = 1'b1;
        clear_stats();
        for (int p = 0; p < 3; p++) begin
            exp_pos_q.push_back(m_pos);
            serve(20, -1, ok);
            model_step();
        end
        checks++; if (obs_pos_q.size() != 3) begin errors++; $display("FAIL restart_count: got %0d expected 3", obs_pos_q.size()); end
        while (obs_pos_q.size() > 0) begin
            o = obs_pos_q.pop_front();
            e = -1; if (exp_pos_q.size() > 0) e = exp_pos_q.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL restart_pos: got %0d expected %0d", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_single_position();
        test_sweep();
        test_timeout();
        test_timeout_race();
        test_ligar_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
